imem_dmem_port_arbiter: RTL

Shares the single-ported, byte-write-enabled synchronous memory between the core's instruction-fetch stage and the load/store (execute) stage. The block is a per-cycle arbiter plus a one-deep read-return tracker. It generates the pipeline stall the controller needs when a requester is not granted. It sits between the fetch/execute datapath and the memory macro.

---
 rtl/imem_dmem_port_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/imem_dmem_port_arbiter.sv
// Shares one single-ported synchronous memory between instruction fetch and load/store.
// Per-cycle combinational arbitration with starvation guard, plus a one-deep read-return tracker.
module imem_dmem_port_arbiter #(
   parameter int unsigned ADDR_W     = 14,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic [3:0]        d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              stall
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IF,
      OWN_DRD
   } owner_t;

   owner_t            owner;
   owner_t            owner_nxt;
   logic [CNT_W-1:0]  starve_cnt;
   logic [CNT_W-1:0]  starve_nxt;
   logic [DATA_W-1:0] if_hold;
   logic [DATA_W-1:0] d_hold;
   logic              fetch_wins;

   // Return owner, starvation counter and per-port read-data hold registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner      <= OWN_NONE;
         starve_cnt <= '0;
         if_hold    <= '0;
         d_hold     <= '0;
      end else begin
         owner      <= owner_nxt;
         starve_cnt <= starve_nxt;
         if (owner == OWN_IF)  if_hold <= mem_dout;
         if (owner == OWN_DRD) d_hold  <= mem_dout;
      end
   end

   // Arbitration, memory drive and next-state decode
   always_comb begin
      if_gnt     = 1'b0;
      d_gnt      = 1'b0;
      mem_we     = '0;
      mem_addr   = '0;
      mem_din    = '0;
      owner_nxt  = OWN_NONE;
      starve_nxt = starve_cnt;
      fetch_wins = if_req && (!d_req || (starve_cnt == CNT_MAX));

      if (fetch_wins) begin
         if_gnt    = 1'b1;
         mem_addr  = if_addr;
         owner_nxt = OWN_IF;
      end else if (d_req) begin
         d_gnt    = 1'b1;
         mem_addr = d_addr;
         mem_we   = d_we;
         mem_din  = d_wdata;
         if (d_we == 4'b0000) owner_nxt = OWN_DRD;
      end

      // Counts data grants that made a waiting fetch lose
      if (if_gnt || !if_req) begin
         starve_nxt = '0;
      end else if (d_gnt && (starve_cnt != CNT_MAX)) begin
         starve_nxt = starve_cnt + CNT_W'(1);
      end

      mem_en = (if_gnt | d_gnt) & ~rst;
      stall  = (if_req & ~if_gnt) | (d_req & ~d_gnt);
   end

   assign if_rvalid = (owner == OWN_IF);
   assign d_rvalid  = (owner == OWN_DRD);
   assign if_rdata  = if_rvalid ? mem_dout : if_hold;
   assign d_rdata   = d_rvalid  ? mem_dout : d_hold;

endmodule
